// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the EX-stage divide sequencer.
//               State encoding, default sizing, the divide-by-zero quotient
//               pattern and helpers that split the divider's {rem, quot}
//               result bus.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DIV_ITERS = 33;

    // Quotient reported for an unsigned divide by zero.
    localparam logic [DEF_WIDTH-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LATCH = 2'd2,
        WB    = 2'd3
    } div_state_t;

    // Remainder lives in the upper half of the divider output.
    function automatic logic [DEF_WIDTH-1:0] res_rem(input logic [2*DEF_WIDTH-1:0] res);
        return res[2*DEF_WIDTH-1:DEF_WIDTH];
    endfunction

    // Quotient lives in the lower half of the divider output.
    function automatic logic [DEF_WIDTH-1:0] res_quot(input logic [2*DEF_WIDTH-1:0] res);
        return res[DEF_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_if
// Description : Bus between the divide sequencer (master) and the restoring
//               divider datapath (slave).
// Signals     : div_dividend / div_divisor - registered operands to divider
//               div_signal                 - 1 = iterate, 0 = latch output
//               div_clear                  - synchronous clear of divider
//               div_result                 - {rem, quot} from divider
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0]   div_dividend;
    logic [WIDTH-1:0]   div_divisor;
    logic               div_signal;
    logic               div_clear;
    logic [2*WIDTH-1:0] div_result;

    modport master (
        output div_dividend,
        output div_divisor,
        output div_signal,
        output div_clear,
        input  div_result
    );

    modport slave (
        input  div_dividend,
        input  div_divisor,
        input  div_signal,
        input  div_clear,
        output div_result
    );

endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl_hilo_regs.sv
`default_nettype none
// ============================================================================
// Module      : hilo_regs
// Description : Architectural HI/LO registers with a prioritised write mux.
//               Priority: divide-by-zero bypass > divide writeback > MTHI/MTLO.
// Ports       : clk, reset (async, active-low)
//               dz_we / dz_hi           - divide-by-zero write (HI=dividend)
//               wb_we / wb_hi / wb_lo   - divide result writeback
//               mthi_we / mtlo_we/wdata - move-to writes
//               hi / lo                 - register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_regs
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             dz_we,
    input  wire logic [WIDTH-1:0] dz_hi,
    input  wire logic             wb_we,
    input  wire logic [WIDTH-1:0] wb_hi,
    input  wire logic [WIDTH-1:0] wb_lo,
    input  wire logic             mthi_we,
    input  wire logic             mtlo_we,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] hi,
    output logic      [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] C_DZ_QUOT = '1;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (dz_we) begin
            // Divide-by-zero writes both halves and overrides any MTHI/MTLO.
            r_hi <= dz_hi;
            r_lo <= C_DZ_QUOT;
        end else if (wb_we) begin
            r_hi <= wb_hi;
            r_lo <= wb_lo;
        end else begin
            if (mthi_we) begin
                r_hi <= wdata;
            end
            if (mtlo_we) begin
                r_lo <= wdata;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Sequencer for the multi-cycle unsigned restoring divider in
//               EX. Latches DIVU operands, holds the divider cleared while
//               idle, runs it for DIV_ITERS cycles, latches and writes the
//               {rem, quot} result into HI/LO, services MTHI/MTLO and stalls
//               the pipeline on HI/LO hazards while a divide is in flight.
// Ports       : clk, reset (async, active-low)
//               start, dividend, divisor - DIVU issue from EX
//               flush                    - squash in-flight divide
//               mfhi/mflo/mthi/mtlo,wdata- HI/LO instructions in EX
//               hi, lo                   - architectural registers
//               busy, stall, dz          - status
//               dbus (master)            - divider datapath bus
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV_ITERS = DEF_DIV_ITERS
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    input  wire logic [WIDTH-1:0] divisor,
    input  wire logic             flush,
    input  wire logic             mfhi,
    input  wire logic             mflo,
    input  wire logic             mthi,
    input  wire logic             mtlo,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] hi,
    output logic      [WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  stall,
    output logic                  dz,
    div_seq_ctrl_if.master        dbus
);

    localparam int               CNT_W  = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV_ITERS - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_dz;
    logic             r_signal;
    logic             r_clear;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;

    logic w_idle;
    logic w_accept;
    logic w_div0;
    logic w_go;
    logic w_wb;

    assign w_idle   = (r_state == IDLE);
    // A start under flush is squashed along with the rest of EX.
    assign w_accept = start & w_idle & ~flush;
    assign w_div0   = w_accept & (divisor == '0);
    assign w_go     = w_accept & ~w_div0;
    assign w_wb     = (r_state == WB) & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_dz       <= 1'b0;
            r_signal   <= 1'b0;
            r_clear    <= 1'b1;
            r_dividend <= '0;
            r_divisor  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_cnt      <= '0;
                        r_dz       <= 1'b0;
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_signal   <= 1'b1;
                        r_clear    <= 1'b0;
                    end else if (w_div0) begin
                        r_dz <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_signal <= 1'b0;
                        r_clear  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST) begin
                            // Dropping div_signal makes the divider latch
                            // its output on the following edge.
                            r_state  <= LATCH;
                            r_signal <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    if (flush) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_clear <= 1'b1;
                    end else begin
                        r_state <= WB;
                    end
                end
                WB: begin
                    // HI/LO write (unless flushed) happens in hilo_regs.
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_clear <= 1'b1;
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_signal <= 1'b0;
                    r_clear  <= 1'b1;
                end
            endcase
        end
    end

    // Move-to writes are only taken while idle; during a divide they are
    // stalled and re-presented by the held pipeline.
    hilo_regs #(
        .WIDTH (WIDTH)
    ) u_hilo_regs (
        .clk     (clk),
        .reset   (reset),
        .dz_we   (w_div0),
        .dz_hi   (dividend),
        .wb_we   (w_wb),
        .wb_hi   (dbus.div_result[2*WIDTH-1:WIDTH]),
        .wb_lo   (dbus.div_result[WIDTH-1:0]),
        .mthi_we (mthi & w_idle),
        .mtlo_we (mtlo & w_idle),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo)
    );

    assign busy  = r_busy;
    assign dz    = r_dz;
    assign stall = r_busy & (start | mfhi | mflo | mthi | mtlo);

    assign dbus.div_dividend = r_dividend;
    assign dbus.div_divisor  = r_divisor;
    assign dbus.div_signal   = r_signal;
    assign dbus.div_clear    = r_clear;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq_ctrl
// Description : Self-checking bench for div_seq_ctrl with a behavioural
//               divider stand-in and an arithmetic HI/LO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         mfhi = 1'b0;
    logic         mflo = 1'b0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stall;
    logic         dz;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    always #5 clk = ~clk;

    div_seq_ctrl_if #(.WIDTH(W)) dbus ();

    div_seq_ctrl #(
        .WIDTH     (W),
        .DIV_ITERS (33)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .mfhi     (mfhi),
        .mflo     (mflo),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall),
        .dz       (dz),
        .dbus     (dbus)
    );

    // Divider stand-in: cleared while div_clear, latches {rem, quot} of the
    // presented operands on an edge where it is neither cleared nor iterating.
    always @(posedge clk or negedge reset) begin
        if (!reset || dbus.div_clear) begin
            dbus.div_result <= '0;
        end else if (!dbus.div_signal && dbus.div_divisor != '0) begin
            dbus.div_result <= {dbus.div_dividend % dbus.div_divisor,
                                dbus.div_dividend / dbus.div_divisor};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one DIVU from idle and check its whole timeline.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int           sig_hi;
        int           busy_lo;
        int           early;
        logic [W-1:0] q;
        logic [W-1:0] r;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();                     // edge T
        start = 1'b0;
        if (b == '0) begin
            m_hi = a;
            m_lo = '1;
            m_dz = 1'b1;
            chk({tag, "_dz_hi"}, hi, m_hi);
            chk({tag, "_dz_lo"}, lo, m_lo);
            chk({tag, "_dz_flag"}, dz, 1);
            busy_lo = 0;
            for (int k = 0; k < 4; k++) begin
                if (busy || dbus.div_signal) busy_lo++;
                step();
            end
            chk({tag, "_dz_nobusy"}, busy_lo, 0);
        end else begin
            q = a / b;
            r = a % b;
            sig_hi  = 0;
            busy_lo = 0;
            early   = 0;
            // Samples after edges T .. T+34
            for (int k = 0; k < 35; k++) begin
                if (dbus.div_signal) sig_hi++;
                if (!busy) busy_lo++;
                if (hi !== m_hi || lo !== m_lo) early++;
                step();
            end
            // Now after edge T+35
            m_hi = r;
            m_lo = q;
            m_dz = 1'b0;
            chk({tag, "_sig_cycles"}, sig_hi, 33);
            chk({tag, "_busy_gaps"}, busy_lo, 0);
            chk({tag, "_early_write"}, early, 0);
            chk({tag, "_busy_end"}, busy, 0);
            chk({tag, "_hi"}, hi, m_hi);
            chk({tag, "_lo"}, lo, m_lo);
            chk({tag, "_dz"}, dz, m_dz);
            chk({tag, "_clear"}, dbus.div_clear, 1);
        end
    endtask

    initial begin
        int           n;
        int           bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", dz, 0);
        chk("rst_sig", dbus.div_signal, 0);
        chk("rst_clear", dbus.div_clear, 1);
        chk("rst_stall", stall, 0);
        reset = 1'b1;
        step();

        // Basic and boundary divides
        run_div("d100_7", 32'd100, 32'd7);
        run_div("dmax_1", 32'hFFFF_FFFF, 32'd1);
        run_div("d5_9", 32'd5, 32'd9);
        run_div("dz1234", 32'h1234, 32'd0);
        run_div("d9_2a", 32'd9, 32'd2);

        // MFLO hazard: stalled while busy, then reads new quotient
        dividend = 32'd1000;
        divisor  = 32'd33;
        start    = 1'b1;
        step();
        start = 1'b0;
        mflo  = 1'b1;
        n   = 0;
        bad = 0;
        while (busy && n < 60) begin
            if (!stall) bad++;
            step();
            n++;
        end
        chk("mflo_stall_len", n, 35);
        chk("mflo_stall_gap", bad, 0);
        chk("mflo_stall_end", stall, 0);
        chk("mflo_lo", lo, 32'd30);
        chk("mflo_hi", hi, 32'd10);
        mflo = 1'b0;
        m_hi = 32'd10;
        m_lo = 32'd30;

        // MTHI during busy: held off, then applied after the divide
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        mthi  = 1'b1;
        wdata = 32'hAB;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk("mthi_wait", n, 35);
        chk("mthi_stall_end", stall, 0);
        step();
        mthi = 1'b0;
        m_hi = 32'hAB;
        m_lo = 32'd15;
        chk("mthi_hi", hi, m_hi);
        chk("mthi_lo", lo, m_lo);

        // MTLO coinciding with a real start: both happen, result overwrites
        dividend = 32'd40;
        divisor  = 32'd6;
        start    = 1'b1;
        mtlo     = 1'b1;
        wdata    = 32'h55;
        step();
        start = 1'b0;
        mtlo  = 1'b0;
        chk("mtlo_start_lo", lo, 32'h55);
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        m_hi = 32'd4;
        m_lo = 32'd6;
        chk("mtlo_start_hi_res", hi, m_hi);
        chk("mtlo_start_lo_res", lo, m_lo);

        // MTHI coinciding with a divide-by-zero start: divide-by-zero wins
        dividend = 32'h99;
        divisor  = 32'd0;
        start    = 1'b1;
        mthi     = 1'b1;
        wdata    = 32'h77;
        step();
        start = 1'b0;
        mthi  = 1'b0;
        m_hi = 32'h99;
        m_lo = '1;
        m_dz = 1'b1;
        chk("mthi_dz_hi", hi, m_hi);
        chk("mthi_dz_lo", lo, m_lo);
        chk("mthi_dz_flag", dz, 1);

        // Clear dz with a real divide, then a flushed divide-by-zero start is dropped
        run_div("d21_4", 32'd21, 32'd4);
        dividend = 32'd3;
        divisor  = 32'd0;
        start    = 1'b1;
        flush    = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_idle_hi", hi, m_hi);
        chk("flush_idle_lo", lo, m_lo);
        chk("flush_idle_dz", dz, 0);
        chk("flush_idle_busy", busy, 0);

        // Flush mid-run
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        step();                     // edge T
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        flush = 1'b1;
        step();                     // edge T+21
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_clear", dbus.div_clear, 1);
        chk("flush_sig", dbus.div_signal, 0);
        for (int k = 0; k < 40; k++) step();
        chk("flush_hi_kept", hi, m_hi);
        chk("flush_lo_kept", lo, m_lo);
        run_div("d9_2b", 32'd9, 32'd2);

        // Randomized divides
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            if (i % 4 == 3) rb = '0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = $urandom_range(1, 16);
            run_div($sformatf("rnd%0d", i), ra, rb);
        end

        // Asynchronous reset in the middle of a run
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b0;
        #1;
        chk("amid_rst_busy", busy, 0);
        chk("amid_rst_hi", hi, 0);
        chk("amid_rst_lo", lo, 0);
        chk("amid_rst_clear", dbus.div_clear, 1);
        step();
        reset = 1'b1;
        for (int k = 0; k < 40; k++) step();
        chk("post_rst_hi", hi, 0);
        chk("post_rst_lo", lo, 0);
        chk("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
